// File: rtl/video_playback_sequencer_pkg.sv
// Shared types and constants for the video playback sequencer: state encoding,
// index table geometry and the index entry address helper.
package video_playback_sequencer_pkg;

  localparam int ADDR_W            = 18;
  localparam int DATA_W            = 16;
  localparam int FRAME_W           = 10;
  localparam int ROW_W             = 8;
  localparam int COL_W             = 9;
  localparam int INDEX_ENTRY_WORDS = 2;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_FRAME = 4'd1,
    ST_IDX_LO     = 4'd2,
    ST_IDX_HI     = 4'd3,
    ST_LOAD       = 4'd4,
    ST_WAIT_ROW   = 4'd5,
    ST_START      = 4'd6,
    ST_DECODE     = 4'd7,
    ST_FRAME_END  = 4'd8,
    ST_DONE       = 4'd9
  } state_t;

  // First word of a frame's index entry; wraps modulo the VRAM address space.
  function automatic logic [ADDR_W-1:0] index_entry_addr(input logic [ADDR_W-1:0]  base,
                                                         input logic [FRAME_W-1:0] frame);
    logic [ADDR_W-1:0] offset;
    offset = ADDR_W'(frame) * ADDR_W'(INDEX_ENTRY_WORDS);
    return base + offset;
  endfunction

endpackage

// File: rtl/video_playback_sequencer_if.sv
// Signal bundle between the sequencer (master) and its surroundings (slave):
// display timing, row buffer, decoder and the VRAM read arbiter.
interface video_playback_sequencer_if;
  import video_playback_sequencer_pkg::*;

  // All strobes (*_valid, *_request, *_start, i_frame_start) are single-cycle pulses with
  // no backpressure: the receiver must take the payload in the cycle the strobe is high.
  logic                i_play_enable;
  logic                i_loop;
  logic [ADDR_W-1:0]   i_clip_index_address;
  logic [FRAME_W-1:0]  i_clip_frame_count;
  logic                i_frame_start;
  logic                i_row_request;
  logic [COL_W-1:0]    i_video_column;
  logic                i_video_data_valid;
  logic [DATA_W-1:0]   i_vram_read_data;
  logic                i_vram_read_data_valid;

  logic [ADDR_W-1:0]   o_playback_address;
  logic                o_playback_address_valid;
  logic                o_video_start;
  logic [ADDR_W-1:0]   o_vram_read_address;
  logic                o_vram_read_request;
  logic                o_busy;
  logic                o_clip_done;
  logic [ROW_W-1:0]    o_row;
  logic [FRAME_W-1:0]  o_frame;
  logic                o_sync_error;
  state_t              o_state;

  modport master (
    input  i_play_enable, i_loop, i_clip_index_address, i_clip_frame_count,
           i_frame_start, i_row_request, i_video_column, i_video_data_valid,
           i_vram_read_data, i_vram_read_data_valid,
    output o_playback_address, o_playback_address_valid, o_video_start,
           o_vram_read_address, o_vram_read_request, o_busy, o_clip_done,
           o_row, o_frame, o_sync_error, o_state
  );

  modport slave (
    output i_play_enable, i_loop, i_clip_index_address, i_clip_frame_count,
           i_frame_start, i_row_request, i_video_column, i_video_data_valid,
           i_vram_read_data, i_vram_read_data_valid,
    input  o_playback_address, o_playback_address_valid, o_video_start,
           o_vram_read_address, o_vram_read_request, o_busy, o_clip_done,
           o_row, o_frame, o_sync_error, o_state
  );

endinterface

// File: rtl/video_playback_sequencer.sv
// Frame/row sequencer for the RLE video decoder: fetches each frame's start address
// from the VRAM index table, loads the decoder, then paces one decoded row per row-buffer request.
module video_playback_sequencer
  import video_playback_sequencer_pkg::*;
#(
  parameter int ROWS_PER_FRAME = 240,
  parameter int LAST_COLUMN    = 255
) (
  input logic                        i_master_clk,
  input logic                        i_reset,
  video_playback_sequencer_if.master bus
);

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [ROW_W-1:0]   row_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  play_addr_q;
  logic [ADDR_W-1:0]  vram_addr_q;
  logic [DATA_W-1:0]  addr_lo_q;
  logic               req_sent_q;
  logic               play_valid_q;
  logic               video_start_q;
  logic               vram_req_q;
  logic               clip_done_q;
  logic               sync_error_q;

  logic               play_on;
  logic               row_done;
  logic               last_row;
  logic               last_frame;
  logic               frame_start_err;
  logic               row_request_err;
  logic [FRAME_W-1:0] final_frame;

  assign play_on     = bus.i_play_enable;
  assign row_done    = bus.i_video_data_valid && (bus.i_video_column == COL_W'(LAST_COLUMN));
  assign last_row    = (row_q == ROW_W'(ROWS_PER_FRAME - 1));
  // A frame count of zero plays as a one-frame clip.
  assign final_frame = (bus.i_clip_frame_count == '0) ? '0 : bus.i_clip_frame_count - 1'b1;
  assign last_frame  = (frame_q == final_frame);

  assign frame_start_err = bus.i_frame_start &&
                           !(state_q inside {ST_IDLE, ST_WAIT_FRAME, ST_DONE});
  assign row_request_err = bus.i_row_request &&
                           (state_q inside {ST_IDX_LO, ST_IDX_HI, ST_LOAD, ST_START, ST_DECODE});

  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      frame_q       <= '0;
      row_q         <= '0;
      base_q        <= '0;
      play_addr_q   <= '0;
      vram_addr_q   <= '0;
      addr_lo_q     <= '0;
      req_sent_q    <= 1'b0;
      play_valid_q  <= 1'b0;
      video_start_q <= 1'b0;
      vram_req_q    <= 1'b0;
      clip_done_q   <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      vram_req_q    <= 1'b0;
      play_valid_q  <= 1'b0;
      video_start_q <= 1'b0;
      if (frame_start_err || row_request_err) sync_error_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (play_on) begin
            state_q      <= ST_WAIT_FRAME;
            frame_q      <= '0;
            row_q        <= '0;
            clip_done_q  <= 1'b0;
            sync_error_q <= 1'b0;
          end
        end
        ST_WAIT_FRAME: begin
          if (!play_on) begin
            state_q <= ST_IDLE;
          end else if (bus.i_frame_start) begin
            state_q    <= ST_IDX_LO;
            req_sent_q <= 1'b0;
          end
        end
        // Each index state issues exactly one read, then waits for its data.
        ST_IDX_LO: begin
          if (!req_sent_q) begin
            base_q      <= bus.i_clip_index_address;
            vram_addr_q <= index_entry_addr(bus.i_clip_index_address, frame_q);
            vram_req_q  <= 1'b1;
            req_sent_q  <= 1'b1;
          end else if (bus.i_vram_read_data_valid) begin
            addr_lo_q  <= bus.i_vram_read_data;
            req_sent_q <= 1'b0;
            state_q    <= play_on ? ST_IDX_HI : ST_IDLE;
          end
        end
        ST_IDX_HI: begin
          if (!req_sent_q) begin
            vram_addr_q <= index_entry_addr(base_q, frame_q) + ADDR_W'(1);
            vram_req_q  <= 1'b1;
            req_sent_q  <= 1'b1;
          end else if (bus.i_vram_read_data_valid) begin
            play_addr_q <= {bus.i_vram_read_data[1:0], addr_lo_q};
            req_sent_q  <= 1'b0;
            state_q     <= play_on ? ST_LOAD : ST_IDLE;
          end
        end
        ST_LOAD: begin
          play_valid_q <= 1'b1;
          row_q        <= '0;
          state_q      <= play_on ? ST_WAIT_ROW : ST_IDLE;
        end
        ST_WAIT_ROW: begin
          if (!play_on) begin
            state_q <= ST_IDLE;
          end else if (bus.i_row_request) begin
            state_q <= ST_START;
          end
        end
        // Once started the decoder cannot be aborted, so START always proceeds to DECODE.
        ST_START: begin
          video_start_q <= 1'b1;
          state_q       <= ST_DECODE;
        end
        ST_DECODE: begin
          if (row_done) begin
            if (!play_on) begin
              state_q <= ST_IDLE;
            end else if (last_row) begin
              state_q <= ST_FRAME_END;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= ST_WAIT_ROW;
            end
          end
        end
        ST_FRAME_END: begin
          if (last_frame && !bus.i_loop) begin
            clip_done_q <= 1'b1;
            state_q     <= play_on ? ST_DONE : ST_IDLE;
          end else begin
            frame_q <= last_frame ? '0 : frame_q + 1'b1;
            state_q <= play_on ? ST_WAIT_FRAME : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!play_on) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_playback_address       = play_addr_q;
  assign bus.o_playback_address_valid = play_valid_q;
  assign bus.o_video_start            = video_start_q;
  assign bus.o_vram_read_address      = vram_addr_q;
  assign bus.o_vram_read_request      = vram_req_q;
  assign bus.o_busy                   = !(state_q inside {ST_IDLE, ST_DONE});
  assign bus.o_clip_done              = clip_done_q;
  assign bus.o_row                    = row_q;
  assign bus.o_frame                  = frame_q;
  assign bus.o_sync_error             = sync_error_q;
  assign bus.o_state                  = state_q;

endmodule

// File: tb/tb_video_playback_sequencer.sv
// Bench for video_playback_sequencer: VRAM and decoder responders, a monitor, and
// a frame-level reference model driven by directed steps with randomized clips.
module tb_video_playback_sequencer;
  import video_playback_sequencer_pkg::*;

  localparam int ROWS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_playback_sequencer_if bus();

  video_playback_sequencer #(.ROWS_PER_FRAME(ROWS), .LAST_COLUMN(255)) dut (
    .i_master_clk(clk),
    .i_reset     (rst),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] got_rd_q[$];
  logic [ADDR_W-1:0] got_ld_q[$];
  logic [DATA_W-1:0] mem [int];
  int                n_start = 0;
  logic [31:0]       got_rows = '0;
  logic [ADDR_W-1:0] last_ld;
  int                m_frame;
  bit                m_done;

  // ---------------- clock/reset helpers and checker ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (!mem.exists(int'(a))) mem[int'(a)] = 16'($urandom);
    return mem[int'(a)];
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      if (bus.o_vram_read_request === 1'b1) got_rd_q.push_back(bus.o_vram_read_address);
      if (bus.o_playback_address_valid === 1'b1) got_ld_q.push_back(bus.o_playback_address);
      if (bus.o_video_start === 1'b1) begin
        n_start++;
        got_rows = {got_rows[23:0], bus.o_row};
      end
    end
  end

  // ---------------- VRAM responder ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    bus.i_vram_read_data_valid = 1'b0;
    bus.i_vram_read_data       = '0;
    forever begin
      tick();
      if (bus.o_vram_read_request === 1'b1) begin
        a = bus.o_vram_read_address;
        repeat ($urandom_range(0, 2)) tick();
        bus.i_vram_read_data       = mem_rd(a);
        bus.i_vram_read_data_valid = 1'b1;
        tick();
        bus.i_vram_read_data_valid = 1'b0;
      end
    end
  end

  // ---------------- decoder responder ----------------
  initial begin
    int n;
    bus.i_video_data_valid = 1'b0;
    bus.i_video_column     = '0;
    forever begin
      tick();
      if (bus.o_video_start === 1'b1) begin
        n = $urandom_range(1, 3);
        repeat ($urandom_range(2, 4)) tick();
        for (int k = 0; k < n; k++) begin
          bus.i_video_column     = 9'($urandom_range(0, 254));
          bus.i_video_data_valid = 1'b1;
          tick();
          bus.i_video_data_valid = 1'b0;
        end
        bus.i_video_column     = 9'd255;
        bus.i_video_data_valid = 1'b1;
        tick();
        bus.i_video_data_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input state_t s, input string tag);
    int n = 0;
    while (bus.o_state !== s && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.o_state), 32'(s));
  endtask

  task automatic wait_video_start();
    int n = 0;
    while (bus.o_video_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("video_start_seen", 32'(bus.o_video_start), 32'd1);
  endtask

  task automatic pulse_row();
    bus.i_row_request = 1'b1;
    tick();
    bus.i_row_request = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
  endtask

  task automatic start_clip(input logic [ADDR_W-1:0] base, input int count, input bit loop_en);
    bus.i_play_enable = 1'b0;
    tick();
    wait_state(ST_IDLE, "clip_idle");
    bus.i_clip_index_address = base;
    bus.i_clip_frame_count   = 10'(count);
    bus.i_loop               = loop_en;
    bus.i_play_enable        = 1'b1;
    tick();
    m_frame = 0;
    m_done  = 1'b0;
    chk("clip_state", 32'(bus.o_state), 32'(ST_WAIT_FRAME));
    chk("clip_err_clear", 32'(bus.o_sync_error), 32'd0);
    chk("clip_done_clear", 32'(bus.o_clip_done), 32'd0);
    chk("clip_frame0", 32'(bus.o_frame), 32'd0);
  endtask

  // Frame advance from the clip rules, applied with the loop/count in force at frame end.
  task automatic model_frame_end();
    int last;
    last = (bus.i_clip_frame_count == '0) ? 0 : int'(bus.i_clip_frame_count) - 1;
    if (m_frame == last) begin
      if (bus.i_loop) m_frame = 0;
      else m_done = 1'b1;
    end else begin
      m_frame++;
    end
  endtask

  // mode 0: normal; 1: stray frame_start mid-frame; 2: stray row_request while decoding;
  // 3: frame_start and row_request together in WAIT_FRAME.
  task automatic play_frame(input int mode);
    logic [ADDR_W-1:0] a0, a1, eld;
    logic [DATA_W-1:0] lo, hi;
    int n;
    a0  = 18'((int'(bus.i_clip_index_address) + 2 * m_frame) % 262144);
    a1  = 18'((int'(a0) + 1) % 262144);
    lo  = mem_rd(a0);
    hi  = mem_rd(a1);
    eld = {hi[1:0], lo};
    exp_q = {a0, a1};
    got_rd_q.delete();
    got_ld_q.delete();
    n_start  = 0;
    got_rows = '0;
    if (mode == 3) bus.i_row_request = 1'b1;
    pulse_frame();
    bus.i_row_request = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      wait_state(ST_WAIT_ROW, "wait_row");
      if (r == 0 && mode == 1) pulse_frame();
      repeat ($urandom_range(0, 2)) tick();
      pulse_row();
      if (r == 0 && mode == 2) begin
        wait_video_start();
        pulse_row();
      end
    end
    n = 0;
    while (!(bus.o_state inside {ST_WAIT_FRAME, ST_DONE}) && n < 200) begin
      tick();
      n++;
    end
    model_frame_end();
    chk("rd_count", 32'(got_rd_q.size()), 32'd2);
    foreach (exp_q[i]) chk("rd_addr", 32'(got_rd_q[i]), 32'(exp_q[i]));
    chk("ld_count", 32'(got_ld_q.size()), 32'd1);
    last_ld = got_ld_q[0];
    chk("ld_addr", 32'(last_ld), 32'(eld));
    chk("start_count", 32'(n_start), 32'(ROWS));
    chk("row_seq", got_rows, 32'h00010203);
    chk("frame", 32'(bus.o_frame), 32'(m_frame));
    chk("clip_done", 32'(bus.o_clip_done), 32'(m_done));
    chk("sync_error", 32'(bus.o_sync_error), 32'(mode == 1 || mode == 2));
    chk("end_state", 32'(bus.o_state), m_done ? 32'(ST_DONE) : 32'(ST_WAIT_FRAME));
    chk("busy", 32'(bus.o_busy), 32'(!m_done));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.i_play_enable        = 1'b0;
    bus.i_loop               = 1'b0;
    bus.i_clip_index_address = '0;
    bus.i_clip_frame_count   = '0;
    bus.i_frame_start        = 1'b0;
    bus.i_row_request        = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_state", 32'(bus.o_state), 32'(ST_IDLE));
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_outs", {bus.o_clip_done, bus.o_sync_error, bus.o_video_start,
                     bus.o_vram_read_request, bus.o_playback_address_valid}, 32'd0);
    chk("rst_row_frame", {bus.o_row, bus.o_frame}, 32'd0);
    chk("rst_addrs", {bus.o_playback_address, bus.o_vram_read_address[13:0]}, 32'd0);

    // Idle: pulses with play disabled do nothing
    got_rd_q.delete();
    got_ld_q.delete();
    n_start = 0;
    pulse_frame();
    pulse_row();
    repeat (5) tick();
    chk("idle_reads", 32'(got_rd_q.size()), 32'd0);
    chk("idle_loads", 32'(got_ld_q.size()), 32'd0);
    chk("idle_starts", 32'(n_start), 32'd0);
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    chk("idle_err", 32'(bus.o_sync_error), 32'd0);

    // Index fetch across the top of VRAM; frame 2 uses simultaneous frame_start/row_request
    mem[0] = 16'h1234;
    mem[1] = 16'h0003;
    start_clip(18'h3FFFE, 3, 1'b0);
    play_frame(0);
    play_frame(0);
    chk("wrap_load", 32'(last_ld), 32'h31234);
    play_frame(3);

    // Looping two-frame clip, then stop looping
    start_clip(18'($urandom), 2, 1'b1);
    repeat (3) play_frame(0);
    bus.i_loop = 1'b0;
    play_frame(0);
    pulse_frame();
    tick();
    chk("done_fs_err", 32'(bus.o_sync_error), 32'd0);
    chk("done_hold", 32'(bus.o_state), 32'(ST_DONE));

    // Timing faults
    start_clip(18'($urandom), 4, 1'b0);
    play_frame(2);
    start_clip(18'($urandom), 4, 1'b0);
    play_frame(1);

    // Randomized clips
    repeat (3) begin
      start_clip(18'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int f = 0; f < 4 && !m_done; f++) play_frame(0);
    end

    // Play disabled while the high index word is outstanding
    start_clip(18'($urandom), 3, 1'b0);
    got_rd_q.delete();
    got_ld_q.delete();
    pulse_frame();
    wait_state(ST_IDX_HI, "abort_idx_hi");
    while (bus.o_vram_read_request !== 1'b1 && bus.o_state == ST_IDX_HI) tick();
    bus.i_play_enable = 1'b0;
    wait_state(ST_IDLE, "abort_idle");
    repeat (3) tick();
    chk("abort_reads", 32'(got_rd_q.size()), 32'd2);
    chk("abort_loads", 32'(got_ld_q.size()), 32'd0);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);

    // Reset while decoding row 1 of frame 1
    start_clip(18'($urandom), 4, 1'b1);
    play_frame(0);
    pulse_frame();
    wait_state(ST_WAIT_ROW, "rst_row0");
    pulse_row();
    wait_state(ST_WAIT_ROW, "rst_row1");
    pulse_row();
    wait_video_start();
    chk("pre_rst_row", 32'(bus.o_row), 32'd1);
    chk("pre_rst_frame", 32'(bus.o_frame), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", 32'(bus.o_state), 32'(ST_IDLE));
    chk("mid_rst_row_frame", {bus.o_row, bus.o_frame}, 32'd0);
    chk("mid_rst_outs", {bus.o_busy, bus.o_clip_done, bus.o_sync_error, bus.o_video_start,
                         bus.o_vram_read_request, bus.o_playback_address_valid}, 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
